// File: rtl/vid_scan_converter.sv
// vid_scan_converter: captures a native-resolution pixel stream into an
// on-chip frame buffer and scans it out as a VGA raster. The source image is
// centred in the active area with a black border. The write side and the scan
// side run independently, with no frame lock, so tearing is possible.
module vid_scan_converter #(
    parameter int SRC_W    = 336,
    parameter int SRC_H    = 240,
    parameter int PIX_W    = 16,
    parameter int SCALE    = 1,
    parameter int CLK_DIV  = 4,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             src_blank_n,
    input  logic             src_frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             wr_overflow
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DEPTH = SRC_W * SRC_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int RW    = $clog2(SRC_H + 1);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int SHF   = (SCALE == 2) ? 1 : 0;
    localparam int X_OFF = (H_ACT - SRC_W * SCALE) / 2;
    localparam int Y_OFF = (V_ACT - SRC_H * SCALE) / 2;

    localparam logic [CW-1:0] WCOL_LAST = CW'(SRC_W - 1);
    localparam logic [RW-1:0] WROW_PARK = RW'(SRC_H);
    localparam logic [AW-1:0] SRC_W_A   = AW'(SRC_W);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_S = HW'(H_ACT);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_BEG   = HW'(X_OFF);
    localparam logic [HW-1:0] X_SPAN  = HW'(SRC_W * SCALE);

    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_S = VW'(V_ACT);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_BEG   = VW'(Y_OFF);
    localparam logic [VW-1:0] Y_SPAN  = VW'(SRC_H * SCALE);

    // Decoded per-position flags that travel down the scan pipeline
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic win;
    } scan_flags_t;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [CW-1:0] wcol;
    logic [RW-1:0] wrow;
    logic [AW-1:0] waddr;
    logic          wr_stb;
    logic          wr_parked;
    logic          wr_en;

    // frame_start outranks a coincident strobe; a parked position drops writes
    assign wr_stb    = pix_valid & src_blank_n & ~src_frame_start;
    assign wr_parked = (wrow == WROW_PARK);
    assign wr_en     = wr_stb & ~wr_parked;

    // Write position tracking; waddr runs alongside (wcol, wrow) so no multiply
    always_ff @(posedge clk) begin
        if (reset) begin
            wcol        <= '0;
            wrow        <= '0;
            waddr       <= '0;
            wr_overflow <= 1'b0;
        end else if (src_frame_start) begin
            wcol  <= '0;
            wrow  <= '0;
            waddr <= '0;
        end else if (wr_stb) begin
            if (wr_parked) begin
                wr_overflow <= 1'b1;
            end else begin
                waddr <= waddr + AW'(1);
                if (wcol == WCOL_LAST) begin
                    wcol <= '0;
                    wrow <= wrow + RW'(1);
                end else begin
                    wcol <= wcol + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer: simple dual-port, registered read, read-first
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rdata;
    logic [AW-1:0]    raddr;
    logic             rd_en;

    // Buffer write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[waddr] <= pix_data;
    end

    // Buffer read port; old data wins on a same-address collision
    always_ff @(posedge clk) begin
        if (rd_en) rdata <= mem[raddr];
    end

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [DW-1:0] div;
    logic          ce;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    assign ce = (div == DIV_LAST);

    // Pixel-rate enable divider
    always_ff @(posedge clk) begin
        if (reset)   div <= '0;
        else if (ce) div <= '0;
        else         div <= div + DW'(1);
    end

    // Raster counters, advanced once per VGA pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: decode the raster position and issue the buffer read
    // ------------------------------------------------------------------
    scan_flags_t   s0_flg;
    logic [HW-1:0] hrel;
    logic [VW-1:0] vrel;
    logic [HW-1:0] sx;
    logic [VW-1:0] sy;

    // Left/top of the window wraps the unsigned offsets to large values, so
    // one "< span" compare per axis covers both window edges.
    always_comb begin
        hrel       = hcnt - X_BEG;
        vrel       = vcnt - Y_BEG;
        sx         = hrel >> SHF;
        sy         = vrel >> SHF;
        s0_flg.act = (hcnt < H_ACT_S) && (vcnt < V_ACT_S);
        s0_flg.hs  = (hcnt >= HS_BEG) && (hcnt < HS_END);
        s0_flg.vs  = (vcnt >= VS_BEG) && (vcnt < VS_END);
        s0_flg.win = (hrel < X_SPAN) && (vrel < Y_SPAN);
        raddr      = AW'(sy) * SRC_W_A + AW'(sx);
        rd_en      = ce & s0_flg.win;
    end

    // ------------------------------------------------------------------
    // Stage 1: flags wait alongside the buffer read
    // ------------------------------------------------------------------
    scan_flags_t s1_flg;

    // Stage-1 flag register
    always_ff @(posedge clk) begin
        if (reset)   s1_flg <= '0;
        else if (ce) s1_flg <= s0_flg;
    end

    // ------------------------------------------------------------------
    // Stage 2: registered VGA outputs
    // ------------------------------------------------------------------
    logic       show_pix;
    logic [3:0] cr;
    logic [3:0] cg;
    logic [3:0] cb;

    assign show_pix = s1_flg.act & s1_flg.win;
    assign cr       = rdata[11:8];
    assign cg       = rdata[7:4];
    assign cb       = rdata[3:0];

    // Output register: polarity applied here, colour nibbles widened to 8 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (ce) begin
            vga_hs      <= s1_flg.hs ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= s1_flg.vs ? SYNC_POL : ~SYNC_POL;
            vga_blank_n <= s1_flg.act;
            vga_r       <= show_pix ? {cr, cr} : 8'h00;
            vga_g       <= show_pix ? {cg, cg} : 8'h00;
            vga_b       <= show_pix ? {cb, cb} : 8'h00;
        end
    end

    // Pixel bits above the 12-bit colour are stored but never displayed
    generate
        if (PIX_W > 12) begin : g_spare
            logic unused_hi_bits;
            assign unused_hi_bits = ^rdata[PIX_W-1:12];
        end
    endgenerate

endmodule

// File: tb/tb_vid_scan_converter.sv
// Bench for vid_scan_converter on a shrunken raster so whole frames stay
// short. Instance A: 8x6 source at scale 1, centred at (4,3). Instance B:
// 8x6 source at scale 2, which fills the 16x12 active area from (0,0).
module tb_vid_scan_converter;

    localparam int SW = 8, SH = 6, CD = 2;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int HT = 24, VT = 17;
    localparam int FPIX = HT * VT;
    localparam int FCLK = FPIX * CD;

    logic clk, reset;
    logic a_pv, a_fs, a_bn, b_pv, b_fs, b_bn;
    logic [15:0] a_pd, b_pd;
    logic a_hs, a_vs, a_blank_n, a_ovf, b_hs, b_vs, b_blank_n, b_ovf;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

    vid_scan_converter #(
        .SRC_W(SW), .SRC_H(SH), .PIX_W(16), .SCALE(1), .CLK_DIV(CD),
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_valid(a_pv), .pix_data(a_pd),
        .src_blank_n(a_bn), .src_frame_start(a_fs),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_blank_n),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .wr_overflow(a_ovf)
    );

    vid_scan_converter #(
        .SRC_W(SW), .SRC_H(SH), .PIX_W(16), .SCALE(2), .CLK_DIV(CD),
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_valid(b_pv), .pix_data(b_pd),
        .src_blank_n(b_bn), .src_frame_start(b_fs),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_blank_n),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .wr_overflow(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; an output for raster index L is
    // registered at edge (L+2)*CD.
    int ecnt;
    always @(posedge clk) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    typedef struct {
        int          grp;
        int          id;
        int          h;
        int          v;
        logic        bn;
        logic [23:0] rgb;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        int          h;
        int          v;
        logic        bn;
        logic [23:0] rgb;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic void add(input int grp, input int id, input int h, input int v,
                                input logic bn, input logic [23:0] rgb);
        vec_t e;
        e.grp = grp; e.id = id; e.h = h; e.v = v; e.bn = bn; e.rgb = rgb;
        vecs.push_back(e);
    endfunction

    // Scoreboard monitor: compares every entry whose due edge has arrived
    always @(posedge clk) begin : mon
        logic [23:0] got_rgb;
        logic        got_bn;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == ecnt) begin
                got_rgb = (sb[i].id == 0) ? {a_r, a_g, a_b} : {b_r, b_g, b_b};
                got_bn  = (sb[i].id == 0) ? a_blank_n : b_blank_n;
                chk($sformatf("pix%0d(%0d,%0d).rgb", sb[i].id, sb[i].h, sb[i].v), 32'(got_rgb), 32'(sb[i].rgb));
                chk($sformatf("pix%0d(%0d,%0d).blank_n", sb[i].id, sb[i].h, sb[i].v), 32'(got_bn), 32'(sb[i].bn));
                sb.delete(i);
            end
        end
    end

    // Queue one table group against the next whole frame and wait for it
    task automatic run_group(input int g);
        int f, lim;
        sb_t s;
        f = (ecnt / CD) / FPIX + 1;
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                s.due = ((f * FPIX + vecs[i].v * HT + vecs[i].h) + 2) * CD;
                s.id  = vecs[i].id; s.h = vecs[i].h; s.v = vecs[i].v;
                s.bn  = vecs[i].bn; s.rgb = vecs[i].rgb;
                sb.push_back(s);
            end
        end
        lim = ecnt + 3 * FCLK;
        while (sb.size() > 0 && ecnt < lim) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            foreach (sb[i]) begin
                checks++;
                errors++;
                $display("FAIL timeout grp%0d pix%0d(%0d,%0d) got none want due %0d", g, sb[i].id, sb[i].h, sb[i].v, sb[i].due);
            end
            sb.delete();
        end
    endtask

    task automatic drive(input int id, input logic pv, input logic fs, input logic bn, input logic [15:0] d);
        @(negedge clk);
        if (id == 0) begin a_pv = pv; a_fs = fs; a_bn = bn; a_pd = d; end
        else         begin b_pv = pv; b_fs = fs; b_bn = bn; b_pd = d; end
        @(negedge clk);
        a_pv = 1'b0; a_fs = 1'b0; a_bn = 1'b1; a_pd = '0;
        b_pv = 1'b0; b_fs = 1'b0; b_bn = 1'b1; b_pd = '0;
    endtask

    int   hs_fall, hs_pmin, hs_pmax, hs_low, vs_fall, vs_per, vs_low;
    int   bn_rise, bn_min, bn_max, lines, lines_frame, first_hs, len;
    logic phs, pvs, pbn;

    initial begin
        reset = 1'b1;
        a_pv = 1'b0; a_fs = 1'b0; a_bn = 1'b1; a_pd = '0;
        b_pv = 1'b0; b_fs = 1'b0; b_bn = 1'b1; b_pd = '0;

        // group 1: fill with pixel (0,0)=0ABC, rest 0F00 (A at X0=4,Y0=3)
        add(1, 0,  4,  3, 1'b1, 24'hAABBCC);
        add(1, 0,  5,  3, 1'b1, 24'hFF0000);
        add(1, 0,  3,  3, 1'b1, 24'h000000);
        add(1, 0, 12,  3, 1'b1, 24'h000000);
        add(1, 0,  4,  2, 1'b1, 24'h000000);
        add(1, 0, 11,  8, 1'b1, 24'hFF0000);
        add(1, 0,  4,  9, 1'b1, 24'h000000);
        add(1, 0, 18,  3, 1'b0, 24'h000000);
        add(1, 0,  4, 13, 1'b0, 24'h000000);
        // group 2: write ordering
        add(2, 0,  4,  3, 1'b1, 24'h444444);
        add(2, 0,  5,  3, 1'b1, 24'h222222);
        add(2, 0,  6,  3, 1'b1, 24'hFF0000);
        // group 3: overflow leaves the buffer untouched
        add(3, 0,  4,  3, 1'b1, 24'hFF0000);
        add(3, 0, 10,  8, 1'b1, 24'hFF0000);
        add(3, 0, 11,  8, 1'b1, 24'h556677);
        // group 4: scale 2, source (1,1)=0123 covers VGA (2..3, 2..3)
        add(4, 1,  1,  1, 1'b1, 24'h000000);
        add(4, 1,  2,  2, 1'b1, 24'h112233);
        add(4, 1,  3,  2, 1'b1, 24'h112233);
        add(4, 1,  4,  2, 1'b1, 24'h000000);
        add(4, 1,  1,  2, 1'b1, 24'h000000);
        add(4, 1,  2,  3, 1'b1, 24'h112233);
        add(4, 1,  3,  3, 1'b1, 24'h112233);
        add(4, 1, 15, 11, 1'b1, 24'h000000);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.hs", 32'(a_hs), 32'd1);
        chk("rst.vs", 32'(a_vs), 32'd1);
        chk("rst.blank_n", 32'(a_blank_n), 32'd0);
        chk("rst.rgb", 32'({a_r, a_g, a_b}), 32'd0);
        chk("rst.wr_overflow", 32'(a_ovf), 32'd0);
        reset = 1'b0;

        // first hs low: counter reaches HA+HF, plus two pipeline ticks
        first_hs = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!a_hs) begin first_hs = ecnt; break; end
        end
        chk("first_hs_low_clk", 32'(first_hs), 32'((HA + HF + 2) * CD));

        // raster timing over two frames
        hs_fall = ecnt; hs_pmin = 1 << 30; hs_pmax = 0; hs_low = 0;
        vs_fall = -1; vs_per = 0; vs_low = 0;
        bn_rise = 0; bn_min = 1 << 30; bn_max = 0; lines = 0; lines_frame = -1;
        phs = a_hs; pvs = a_vs; pbn = a_blank_n;
        repeat (2 * FCLK + 100) begin
            @(posedge clk); #1;
            if (phs && !a_hs) begin
                len = ecnt - hs_fall;
                if (len < hs_pmin) hs_pmin = len;
                if (len > hs_pmax) hs_pmax = len;
                hs_fall = ecnt;
            end
            if (!phs && a_hs) hs_low = ecnt - hs_fall;
            if (pvs && !a_vs) begin
                if (vs_fall >= 0) begin vs_per = ecnt - vs_fall; lines_frame = lines; end
                vs_fall = ecnt;
                lines = 0;
            end
            if (!pvs && a_vs && vs_fall >= 0) vs_low = ecnt - vs_fall;
            if (!pbn && a_blank_n) begin bn_rise = ecnt; lines++; end
            if (pbn && !a_blank_n) begin
                len = ecnt - bn_rise;
                if (len < bn_min) bn_min = len;
                if (len > bn_max) bn_max = len;
            end
            phs = a_hs; pvs = a_vs; pbn = a_blank_n;
        end
        chk("hs_period_min", 32'(hs_pmin), 32'(HT * CD));
        chk("hs_period_max", 32'(hs_pmax), 32'(HT * CD));
        chk("hs_low", 32'(hs_low), 32'(HS * CD));
        chk("vs_period", 32'(vs_per), 32'(VT * HT * CD));
        chk("vs_low", 32'(vs_low), 32'(VS * HT * CD));
        chk("active_px_min", 32'(bn_min), 32'(HA * CD));
        chk("active_px_max", 32'(bn_max), 32'(HA * CD));
        chk("active_lines", 32'(lines_frame), 32'(VA));

        // fill
        drive(0, 1'b0, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < SW * SH; i++)
            drive(0, 1'b1, 1'b0, 1'b1, (i == 0) ? 16'h0ABC : 16'h0F00);
        run_group(1);

        // write ordering: blanked strobe and frame_start+strobe write nothing
        drive(0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(0, 1'b1, 1'b0, 1'b1, 16'h0111);
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0FFF);
        drive(0, 1'b1, 1'b0, 1'b1, 16'h0222);
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0333);
        drive(0, 1'b1, 1'b0, 1'b1, 16'h0444);
        run_group(2);

        // overflow
        drive(0, 1'b0, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < SW * SH; i++)
            drive(0, 1'b1, 1'b0, 1'b1, (i == SW * SH - 1) ? 16'h0567 : 16'h0F00);
        chk("ovf_after_last_entry", 32'(a_ovf), 32'd0);
        drive(0, 1'b1, 1'b0, 1'b1, 16'h0ABC);
        chk("ovf_after_extra_strobe", 32'(a_ovf), 32'd1);
        run_group(3);
        drive(0, 1'b0, 1'b1, 1'b1, 16'h0000);
        chk("ovf_kept_by_frame_start", 32'(a_ovf), 32'd1);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovf_cleared_by_reset", 32'(a_ovf), 32'd0);
        reset = 1'b0;

        // scale 2
        drive(1, 1'b0, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < SW * SH; i++)
            drive(1, 1'b1, 1'b0, 1'b1, (i == SW + 1) ? 16'h0123 : 16'h0000);
        chk("b_ovf_full_frame", 32'(b_ovf), 32'd0);
        run_group(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
